// File: rtl/alu32_seq_ctrl_pkg.sv
// Shared widths, opcodes, ALU function encodings and flag positions for the 32-bit ALU sequencer.
package alu32_seq_ctrl_pkg;

    localparam int unsigned HALF_W  = 16;
    localparam int unsigned DATA_W  = 2 * HALF_W;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned S_W     = 4;
    localparam int unsigned FLAGS_W = 5;

    // Command opcodes; 6 and 7 are reserved
    localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 3'd1;
    localparam logic [OP_W-1:0] OP_AND   = 3'd2;
    localparam logic [OP_W-1:0] OP_OR    = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
    localparam logic [OP_W-1:0] OP_PASSA = 3'd5;

    // 74181 function selects (active-high data)
    localparam logic [S_W-1:0] S_ADD   = 4'b1001;
    localparam logic [S_W-1:0] S_SUB   = 4'b0110;
    localparam logic [S_W-1:0] S_AND   = 4'b1011;
    localparam logic [S_W-1:0] S_OR    = 4'b1110;
    localparam logic [S_W-1:0] S_XOR   = 4'b0110;
    localparam logic [S_W-1:0] S_PASSA = 4'b1111;
    localparam logic [S_W-1:0] S_IDLE  = 4'b0000;

    localparam logic M_ARITH = 1'b0;
    localparam logic M_LOGIC = 1'b1;

    // Bit positions within {ERR,V,C,N,Z}
    localparam int unsigned FLAG_Z   = 0;
    localparam int unsigned FLAG_N   = 1;
    localparam int unsigned FLAG_C   = 2;
    localparam int unsigned FLAG_V   = 3;
    localparam int unsigned FLAG_ERR = 4;

    // Latched command payload
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    // Per-opcode ALU control
    typedef struct packed {
        logic           m;
        logic [S_W-1:0] s;
        logic           cin_lo_n;
        logic           is_arith;
        logic           is_rsvd;
    } dec_t;

endpackage

// File: rtl/alu32_seq_ctrl_if.sv
// Command and result valid/ready ports of the 32-bit ALU sequencer.
interface alu32_seq_ctrl_if;
    import alu32_seq_ctrl_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [OP_W-1:0]     cmd_op;
    logic [DATA_W-1:0]   cmd_a;
    logic [DATA_W-1:0]   cmd_b;
    logic                res_valid;
    logic                res_ready;
    logic [DATA_W-1:0]   res_data;
    logic [FLAGS_W-1:0]  res_flags;

    // Requester side: issues commands and consumes results
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_flags
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_flags
    );

endinterface

// File: rtl/alu32_seq_ctrl_op_decode.sv
// Combinational opcode decode into 74181 mode, function select and low-pass carry-in.
module alu32_seq_ctrl_op_decode
    import alu32_seq_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output dec_t            dec_c
);

    // Opcode to ALU control; anything unlisted is reserved and leaves the ALU idle
    always_comb begin
        dec_c          = '0;
        dec_c.m        = M_LOGIC;
        dec_c.s        = S_IDLE;
        dec_c.cin_lo_n = 1'b1;
        case (op)
            OP_ADD: begin
                dec_c.m        = M_ARITH;
                dec_c.s        = S_ADD;
                dec_c.is_arith = 1'b1;
            end
            OP_SUB: begin
                dec_c.m        = M_ARITH;
                dec_c.s        = S_SUB;
                dec_c.cin_lo_n = 1'b0;
                dec_c.is_arith = 1'b1;
            end
            OP_AND:   dec_c.s = S_AND;
            OP_OR:    dec_c.s = S_OR;
            OP_XOR:   dec_c.s = S_XOR;
            OP_PASSA: dec_c.s = S_PASSA;
            default:  dec_c.is_rsvd = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu32_seq_ctrl.sv
// Runs 32-bit ops as two chained 16-bit passes through an external 74181-style ALU.
module alu32_seq_ctrl
    import alu32_seq_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    alu32_seq_ctrl_if.slave    bus,
    output logic [HALF_W-1:0]  alu_a,
    output logic [HALF_W-1:0]  alu_b,
    output logic [S_W-1:0]     alu_s,
    output logic               alu_m,
    output logic               alu_cin_n,
    input  logic [HALF_W-1:0]  alu_f,
    input  logic               alu_cout_n
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]          state, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [HALF_W-1:0]   r_lo_q, r_lo_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                res_valid_q, res_valid_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [FLAGS_W-1:0]  res_flags_q, res_flags_d;
    logic [HALF_W-1:0]   alu_a_d, alu_b_d;
    logic [S_W-1:0]      alu_s_d;
    logic                alu_m_d, alu_cin_n_d;
    logic [OP_W-1:0]     op_sel_c;
    dec_t                dec_c;
    logic [DATA_W-1:0]   r_full_c;
    logic                is_sub_c;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_flags = res_flags_q;

    // Decode the incoming op while idle, the latched op afterwards
    assign op_sel_c = (state == ST_IDLE) ? bus.cmd_op : cmd_q.op;
    assign r_full_c = {alu_f, r_lo_q};
    assign is_sub_c = (cmd_q.op == OP_SUB);

    alu32_seq_ctrl_op_decode u_decode (
        .op    (op_sel_c),
        .dec_c (dec_c)
    );

    // Next state, next ALU drive and result/flag capture
    always_comb begin
        state_d     = state;
        cmd_d       = cmd_q;
        r_lo_d      = r_lo_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_s_d     = S_IDLE;
        alu_m_d     = M_LOGIC;
        alu_cin_n_d = 1'b1;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d.op = bus.cmd_op;
                    cmd_d.a  = bus.cmd_a;
                    cmd_d.b  = bus.cmd_b;
                    state_d  = ST_LO;
                    if (!dec_c.is_rsvd) begin
                        alu_a_d     = bus.cmd_a[HALF_W-1:0];
                        alu_b_d     = bus.cmd_b[HALF_W-1:0];
                        alu_s_d     = dec_c.s;
                        alu_m_d     = dec_c.m;
                        alu_cin_n_d = dec_c.cin_lo_n;
                    end
                end
            end
            ST_LO: begin
                r_lo_d  = alu_f;
                state_d = ST_HI;
                if (!dec_c.is_rsvd) begin
                    alu_a_d     = cmd_q.a[DATA_W-1:HALF_W];
                    alu_b_d     = cmd_q.b[DATA_W-1:HALF_W];
                    alu_s_d     = dec_c.s;
                    alu_m_d     = dec_c.m;
                    // Low-pass carry chains into the high pass for arithmetic only
                    alu_cin_n_d = dec_c.is_arith ? alu_cout_n : 1'b1;
                end
            end
            ST_HI: begin
                state_d     = ST_DONE;
                res_flags_d = '0;
                if (dec_c.is_rsvd) begin
                    res_data_d            = '0;
                    res_flags_d[FLAG_ERR] = 1'b1;
                end else begin
                    res_data_d          = r_full_c;
                    res_flags_d[FLAG_Z] = (r_full_c == '0);
                    res_flags_d[FLAG_N] = r_full_c[DATA_W-1];
                    if (dec_c.is_arith) begin
                        res_flags_d[FLAG_C] = ~alu_cout_n;
                        if (is_sub_c)
                            res_flags_d[FLAG_V] = (cmd_q.a[DATA_W-1] != cmd_q.b[DATA_W-1]) &&
                                                  (r_full_c[DATA_W-1] != cmd_q.a[DATA_W-1]);
                        else
                            res_flags_d[FLAG_V] = (cmd_q.a[DATA_W-1] == cmd_q.b[DATA_W-1]) &&
                                                  (r_full_c[DATA_W-1] != cmd_q.a[DATA_W-1]);
                    end
                end
            end
            default: begin
                if (bus.res_ready)
                    state_d = ST_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    // Operand, result and registered output updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q       <= '0;
            r_lo_q      <= '0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_s       <= S_IDLE;
            alu_m       <= M_LOGIC;
            alu_cin_n   <= 1'b1;
        end else begin
            cmd_q       <= cmd_d;
            r_lo_q      <= r_lo_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            alu_a       <= alu_a_d;
            alu_b       <= alu_b_d;
            alu_s       <= alu_s_d;
            alu_m       <= alu_m_d;
            alu_cin_n   <= alu_cin_n_d;
        end
    end

endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// Bench for alu32_seq_ctrl: behavioural 16-bit ALU slice plus a 32-bit arithmetic reference model.
module tb_alu32_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] alu_a, alu_b, alu_f;
    logic [3:0]  alu_s;
    logic        alu_m, alu_cin_n, alu_cout_n;
    logic [16:0] sum17;

    int errors = 0;
    int checks = 0;

    alu32_seq_ctrl_if bus ();

    alu32_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_cin_n  (alu_cin_n),
        .alu_f      (alu_f),
        .alu_cout_n (alu_cout_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit 74181-style slice for the functions the controller uses
    always_comb begin
        sum17      = '0;
        alu_f      = '0;
        alu_cout_n = 1'b1;
        if (!alu_m) begin
            case (alu_s)
                4'b1001: sum17 = {1'b0, alu_a} + {1'b0, alu_b} + 17'(!alu_cin_n);
                4'b0110: sum17 = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'(!alu_cin_n);
                default: sum17 = '0;
            endcase
            alu_f      = sum17[15:0];
            alu_cout_n = ~sum17[16];
        end else begin
            case (alu_s)
                4'b1111: alu_f = alu_a;
                4'b1011: alu_f = alu_a & alu_b;
                4'b1110: alu_f = alu_a | alu_b;
                4'b0110: alu_f = alu_a ^ alu_b;
                default: alu_f = '0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: result and {ERR,V,C,N,Z}
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f);
        logic [32:0] w;
        logic c, v, err;
        r = '0; c = 1'b0; v = 1'b0; err = 1'b0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a;
            default: err = 1'b1;
        endcase
        if (err) f = 5'b10000;
        else     f = {1'b0, v, c, r[31], (r == 32'd0)};
    endfunction

    // Issue one op from IDLE, hold res_ready low for 'hold' cycles, then complete the handshake
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold,
                          output logic lo_cout_n, output logic lo_m, output logic [3:0] lo_s,
                          output logic hi_cin_n);
        logic [31:0] er;
        logic [4:0]  ef;
        int lat;
        model(op, a, b, er, ef);
        chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.res_ready = (hold == 0);
        @(posedge clk); @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_a     = $urandom;
        bus.cmd_b     = $urandom;
        lat       = 1;
        lo_cout_n = alu_cout_n;
        lo_m      = alu_m;
        lo_s      = alu_s;
        chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        lat      = 2;
        hi_cin_n = alu_cin_n;
        chk("res_valid_early", 64'(bus.res_valid), 64'd0);
        @(posedge clk); @(negedge clk);
        lat = 3;
        while (!bus.res_valid && lat < 12) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'd3);
        chk("res_data", 64'(bus.res_data), 64'(er));
        chk("res_flags", 64'(bus.res_flags), 64'(ef));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_valid", 64'(bus.res_valid), 64'd1);
            chk("hold_data", 64'(bus.res_data), 64'(er));
            chk("hold_flags", 64'(bus.res_flags), 64'(ef));
            chk("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_valid", 64'(bus.res_valid), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Hard stop if anything stalls beyond the expected run time
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       lc, lm, hc;
        logic [3:0] ls;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data", 64'(bus.res_data), 64'd0);
        chk("rst_res_flags", 64'(bus.res_flags), 64'd0);
        chk("rst_alu_m", 64'(alu_m), 64'd1);
        chk("rst_alu_cin_n", 64'(alu_cin_n), 64'd1);
        chk("rst_alu_s", 64'(alu_s), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Low-half carry chains into the high half
        run_op(3'd0, 32'h0000_FFFF, 32'h0000_0001, 0, lc, lm, ls, hc);
        chk("t1_lo_cout_n", 64'(lc), 64'd0);
        chk("t1_hi_cin_n", 64'(hc), 64'd0);
        run_op(3'd1, 32'h0000_0005, 32'h0000_0005, 0, lc, lm, ls, hc);
        run_op(3'd1, 32'h0000_0003, 32'h0000_0005, 0, lc, lm, ls, hc);
        run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, lc, lm, ls, hc);
        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0, lc, lm, ls, hc);
        run_op(3'd4, 32'hF0F0_1234, 32'hFFFF_0000, 0, lc, lm, ls, hc);
        chk("t4_lo_m", 64'(lm), 64'd1);
        chk("t4_lo_s", 64'(ls), 64'(4'b0110));
        chk("t4_hi_cin_n", 64'(hc), 64'd1);
        run_op(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 0, lc, lm, ls, hc);
        run_op(3'd0, 32'h1111_2222, 32'h3333_4444, 5, lc, lm, ls, hc);
        run_op(3'd0, 32'h0000_0002, 32'h0000_0003, 0, lc, lm, ls, hc);

        // Reset during the high pass discards the op
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 32'h1234_0001;
        bus.cmd_b     = 32'h0001_0001;
        @(posedge clk); @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t6_hi_alu_a", 64'(alu_a), 64'h1234);
        rst = 1'b1;
        #1;
        chk("t6_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("t6_res_valid", 64'(bus.res_valid), 64'd0);
        chk("t6_res_data", 64'(bus.res_data), 64'd0);
        chk("t6_res_flags", 64'(bus.res_flags), 64'd0);
        chk("t6_alu_a", 64'(alu_a), 64'd0);
        chk("t6_alu_b", 64'(alu_b), 64'd0);
        chk("t6_alu_s", 64'(alu_s), 64'd0);
        chk("t6_alu_m", 64'(alu_m), 64'd1);
        chk("t6_alu_cin_n", 64'(alu_cin_n), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_valid", 64'(bus.res_valid), 64'd0);
        end
        run_op(3'd0, 32'h0000_0001, 32'h0000_0001, 0, lc, lm, ls, hc);

        // Randomized ops with occasional back-pressure
        for (int n = 0; n < 80; n++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2), lc, lm, ls, hc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
